// File: rtl/word_align_pkg.sv
// word_align_pkg: shared types, widths and helpers for the word-alignment stage.
package word_align_pkg;
    localparam int WORD_W   = 8;
    localparam int OFFSET_W = 3;
    localparam int CNT_W    = 32;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } state_t;
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/word_align_ctrl_shifter.sv
// word_shifter: holds the previous word, extracts the offset window and registers the aligned byte.
module word_shifter
    import word_align_pkg::*;
(
    input  logic                clk160,
    input  logic                rstb,
    input  logic [WORD_W-1:0]   data_in,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                valid_in,
    output logic [WORD_W-1:0]   win,
    output logic [WORD_W-1:0]   data_out,
    output logic                data_out_valid
);
    logic [WORD_W-1:0]   prev_q, prev_d, data_out_q, data_out_d;
    logic                valid_q, valid_d;
    logic [2*WORD_W-1:0] cat;
    always_comb begin
        cat        = {data_in, prev_q};
        win        = cat[offset +: WORD_W];
        prev_d     = data_in;
        data_out_d = win;
        valid_d    = valid_in;
    end
    always_ff @(posedge clk160) begin
        if (!rstb) begin
            prev_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end
    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
endmodule

// File: rtl/word_align_ctrl.sv
// word_align_ctrl: byte-boundary search/lock FSM over a bit-aligned 8-bit stream.
// Define WORD_ALIGN_ERRCNT_EN to build the checked-word / error statistics counters.
module word_align_ctrl
    import word_align_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                clk160,
    input  logic                rstb,
    input  logic [WORD_W-1:0]   data_in,
    input  logic                delay_ready,
    input  logic                enable,
    input  logic                manual_mode,
    input  logic [OFFSET_W-1:0] manual_offset,
    input  logic [WORD_W-1:0]   sync_word,
    input  logic                check_en,
    input  logic                reset_counters,
    output logic [WORD_W-1:0]   data_out,
    output logic                data_out_valid,
    output logic                locked,
    output logic [OFFSET_W-1:0] offset,
    output logic [7:0]          sweep_fail_cnt,
    output logic [CNT_W-1:0]    word_counter,
    output logic [CNT_W-1:0]    error_counter
);
    state_t              state_q, state_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [7:0]          match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d, sweep_q, sweep_d;
    logic [WORD_W-1:0]   win;
    logic                hit, adv;
    assign offset = manual_mode ? manual_offset : offset_q;
    assign hit    = (win == sync_word);
    assign locked = (state_q == LOCKED);
    assign sweep_fail_cnt = sweep_q;
    word_shifter u_shifter (
        .clk160         (clk160),
        .rstb           (rstb),
        .data_in        (data_in),
        .offset         (offset),
        .valid_in       (locked || manual_mode),
        .win            (win),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        sweep_d     = sweep_q;
        adv         = 1'b0;
        if (!enable || manual_mode) begin
            state_d     = IDLE;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else if (!delay_ready) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = SEARCH;
                SEARCH: begin
                    if (hit) begin
                        if (LOCK_COUNT == 1) state_d = LOCKED;
                        else state_d = CONFIRM;
                        match_cnt_d = 8'd1;
                        miss_cnt_d  = '0;
                    end else adv = 1'b1;
                end
                CONFIRM: begin
                    if (hit) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                        if (int'(match_cnt_q) + 1 == LOCK_COUNT) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                        adv     = 1'b1;
                    end
                end
                LOCKED: begin
                    if (check_en && !hit) begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                        if (int'(miss_cnt_q) + 1 == UNLOCK_COUNT) begin
                            state_d = SEARCH;
                            adv     = 1'b1;
                        end
                    end else if (check_en) miss_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        // Each rejected offset steps on; rolling over 7 -> 0 completes one failed sweep.
        if (adv) begin
            offset_d = offset_q + 3'd1;
            if (&offset_q) sweep_d = sat_inc8(sweep_q);
        end
    end
    always_ff @(posedge clk160) begin
        if (!rstb) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            sweep_q     <= '0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            sweep_q     <= sweep_d;
        end
    end
`ifdef WORD_ALIGN_ERRCNT_EN
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d, err_cnt_q, err_cnt_d;
    logic             checked;
    always_comb begin
        checked    = enable && !manual_mode && delay_ready && locked && check_en;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (reset_counters) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (checked && !(&word_cnt_q) && !(&err_cnt_q)) begin
            word_cnt_d = word_cnt_q + 1'b1;
            err_cnt_d  = err_cnt_q + CNT_W'(!hit);
        end
    end
    always_ff @(posedge clk160) begin
        if (!rstb) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
    assign word_counter  = word_cnt_q;
    assign error_counter = err_cnt_q;
`else
    logic unused_reset_counters;
    assign unused_reset_counters = reset_counters;
    assign word_counter  = '0;
    assign error_counter = '0;
`endif
endmodule
